// File: rtl/img_tx_scheduler_if.sv
// Handshake bundle between the image TX scheduler, the pixel RAM/grayscale filter and the UART TX FIFO.
// master = scheduler side, slave = datapath/host side.
interface img_tx_scheduler_if #(
    parameter int ADDR_BITS = 10
);
    logic                 start;
    logic [ADDR_BITS-1:0] num_pixels;
    logic [7:0]           pix_data;
    logic                 tx_full;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           tx_data;
    logic                 wr_uart;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] sent_count;

    modport master (
        input  start, num_pixels, pix_data, tx_full,
        output mem_addr, tx_data, wr_uart, busy, done, sent_count
    );

    modport slave (
        output start, num_pixels, pix_data, tx_full,
        input  mem_addr, tx_data, wr_uart, busy, done, sent_count
    );
endinterface

// File: rtl/img_tx_scheduler.sv
// Frame sequencer: walks pixel RAM, waits out RAM+filter latency, writes each byte to the UART when not full.
// Optional GRAY_TRIPLET_EN: every latched byte is written three times (R,G,B of a gray pixel).
module img_tx_scheduler #(
    parameter int ADDR_BITS = 10,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    img_tx_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] sent_q, sent_d;
    logic [7:0]           tx_q, tx_d;
    logic [3:0]           lat_q, lat_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef GRAY_TRIPLET_EN
    logic [1:0]           rep_q, rep_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sent_q  <= '0;
            tx_q    <= '0;
            lat_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GRAY_TRIPLET_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            tx_q    <= tx_d;
            lat_q   <= lat_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GRAY_TRIPLET_EN
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        tx_d    = tx_q;
        lat_d   = lat_q;
`ifdef GRAY_TRIPLET_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.num_pixels;
                    addr_d  = '0;
                    sent_d  = '0;
                    state_d = (bus.num_pixels == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                lat_d   = LAT_INIT;
`ifdef GRAY_TRIPLET_EN
                rep_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    tx_d    = bus.pix_data;
                    state_d = S_CHECK;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (!bus.tx_full) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef GRAY_TRIPLET_EN
                // Re-enter CHECK so tx_full is honoured before every repeat.
                if (rep_q < 2'd2) begin
                    rep_d   = rep_q + 2'd1;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_NEXT;
                end
`else
                state_d = S_NEXT;
`endif
            end
            S_NEXT: begin
                sent_d = sent_q + 1'b1;
                if (addr_q == cnt_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the state being entered so they line up with that state.
        wr_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    assign bus.mem_addr   = addr_q;
    assign bus.tx_data    = tx_q;
    assign bus.wr_uart    = wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_img_tx_scheduler.sv
// Scoreboard bench for img_tx_scheduler: stimulus pushes expected bytes/frame ends, a negedge monitor checks them.
module tb_img_tx_scheduler;
    localparam int AB     = 10;
    localparam int RD_LAT = 1;
`ifdef GRAY_TRIPLET_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif
    localparam int P = RD_LAT + 2 + 2 * REP;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    img_tx_scheduler_if #(.ADDR_BITS(AB)) bus ();

    img_tx_scheduler #(.ADDR_BITS(AB), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int applied     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [7:0] exp_bytes[$];
    int         exp_done[$];
    int         wr_log[$];
    int         done_log[$];
    logic       prev_full = 1'b0;

    function automatic logic [7:0] f(input logic [AB-1:0] a);
        return 8'(a * 29 + 17);
    endfunction

    // RAM + filter model: byte for an address appears RD_LAT cycles after it.
    logic [7:0] pipe[RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= f(bus.mem_addr);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pix_data = pipe[RD_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.wr_uart) begin
                check("wr_after_full", int'(prev_full), 0);
                if (exp_bytes.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    check("tx_data", int'(bus.tx_data), int'(exp_bytes.pop_front()));
                end
                wr_log.push_back(cyc);
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("done_sent_count", int'(bus.sent_count), exp_done.pop_front());
                end
                check("busy_in_done", int'(bus.busy), 1);
                done_log.push_back(cyc);
            end
        end
        prev_full = bus.tx_full;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic start_frame(input int n, output int a);
        a = cyc + 1;
        bus.start      = 1'b1;
        bus.num_pixels = AB'(n);
        for (int p = 0; p < n; p++)
            for (int r = 0; r < REP; r++) exp_bytes.push_back(f(AB'(p)));
        exp_done.push_back(n);
        tick();
        bus.start      = 1'b0;
        bus.num_pixels = AB'(1023);
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_log.size();
        for (int i = 0; i < budget && done_log.size() == n0; i++) tick();
        check("done_seen", int'(done_log.size() > n0), 1);
    endtask

    // Cycle of write r of pixel p for a frame accepted at cycle a; pixels >= sf are delayed by sh.
    function automatic int wr_t(input int a, input int p, input int r, input int sf, input int sh);
        return a + RD_LAT + 2 + p * P + 2 * r + ((p >= sf) ? sh : 0);
    endfunction

    task automatic check_frame(input int a, input int n, input int sf, input int sh);
        check("wr_count", wr_log.size(), n * REP);
        for (int p = 0; p < n; p++)
            for (int r = 0; r < REP; r++)
                if (p * REP + r < wr_log.size())
                    check("wr_time", wr_log[p*REP+r], wr_t(a, p, r, sf, sh));
        check("done_count", done_log.size(), 1);
        if (done_log.size() > 0)
            check("done_time", done_log[0], (n == 0) ? a : wr_t(a, n-1, REP-1, sf, sh) + 2);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({bus.mem_addr, bus.tx_data, bus.wr_uart, bus.busy, bus.done, bus.sent_count}), 0);
    endtask

    initial begin
        int a, t1, set_at, rel, sh;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.num_pixels = '0;
        bus.tx_full    = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        reset = 1'b1;
        tick();

        // Basic 3-pixel frame
        clear_logs();
        start_frame(3, a);
        wait_done(200);
        check_frame(a, 3, 99, 0);
        check("busy_after_done", int'(bus.busy), 0);
        check("sent_count", int'(bus.sent_count), 3);
        check("last_addr", int'(bus.mem_addr), 2);

        // 20-cycle tx_full stall at pixel 1
        clear_logs();
        start_frame(3, a);
        t1     = wr_t(a, 1, 0, 99, 0);
        set_at = t1 - (RD_LAT + 3);
        rel    = set_at + 20;
        sh     = rel + 1 - t1;
        tick_to(set_at);
        bus.tx_full = 1'b1;
        tick_to(set_at + 11);
        check("stall_tx_data", int'(bus.tx_data), int'(f(AB'(1))));
        check("stall_no_wr", wr_log.size(), REP);
        tick_to(rel);
        bus.tx_full = 1'b0;
        wait_done(200);
        check_frame(a, 3, 1, sh);
        check("stall_sent_count", int'(bus.sent_count), 3);

        // Empty frame
        clear_logs();
        start_frame(0, a);
        wait_done(20);
        check_frame(a, 0, 99, 0);
        check("empty_sent_count", int'(bus.sent_count), 0);
        check("empty_busy", int'(bus.busy), 0);

        // start re-pulsed mid-frame with a different count
        clear_logs();
        start_frame(4, a);
        tick_to(wr_t(a, 1, 0, 99, 0) - 2);
        bus.start      = 1'b1;
        bus.num_pixels = AB'(2);
        tick();
        bus.start      = 1'b0;
        wait_done(300);
        repeat (2 * P) tick();
        check_frame(a, 4, 99, 0);
        check("restart_sent_count", int'(bus.sent_count), 4);

        // Asynchronous reset in WAIT of pixel 2, then a clean 2-pixel frame
        clear_logs();
        start_frame(3, a);
        tick_to(wr_t(a, 2, 0, 99, 0) - 2);
        reset = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        check("abort_wr_count", wr_log.size(), 2 * REP);
        exp_bytes.delete();
        exp_done.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_logs();
        start_frame(2, a);
        wait_done(200);
        check_frame(a, 2, 99, 0);
        check("post_reset_sent", int'(bus.sent_count), 2);

        check("bytes_left", exp_bytes.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
